// File: rtl/emern_vga_pkg.sv
// Shared VGA timing constants, scan-control payload and colour packing helpers
// used by the scanout block, the pixel core and the frontend.
package emern_vga_pkg;

    localparam int unsigned VGA_640X480_H_ACTIVE = 640;
    localparam int unsigned VGA_640X480_H_FP     = 16;
    localparam int unsigned VGA_640X480_H_SYNC   = 96;
    localparam int unsigned VGA_640X480_H_BP     = 48;
    localparam int unsigned VGA_640X480_V_ACTIVE = 480;
    localparam int unsigned VGA_640X480_V_FP     = 10;
    localparam int unsigned VGA_640X480_V_SYNC   = 2;
    localparam int unsigned VGA_640X480_V_BP     = 33;

    localparam bit          SYNC_ACTIVE_LOW      = 1'b0;
    localparam int unsigned COLOR_BITS_DEFAULT   = 2;

    // Raw position flags carried through the pixel-latency delay line
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } scan_ctl_t;

    localparam int unsigned SCAN_CTL_W = $bits(scan_ctl_t);

    // Packed {R,G,B} word width for a given per-channel depth
    function automatic int unsigned pixel_width(input int unsigned color_bits);
        return color_bits + color_bits + color_bits;
    endfunction

endpackage

// File: rtl/emern_delay_line.sv
// Enable-gated shift register; DEPTH of zero degenerates to a plain wire.
module emern_delay_line #(
    parameter int unsigned     W         = 1,
    parameter int unsigned     DEPTH     = 1,
    parameter logic [W-1:0]    RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst, en_i};
        assign q_o = d_i;
    end else begin : g_shift
        logic [W-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RESET_VAL;
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/emern_scanout.sv
// Parametrised VGA scanout: scan counters, latency-aligned sync/blank gating,
// and a sticky vblank-start interrupt with acknowledge and overrun flag.
module emern_scanout
    import emern_vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_640X480_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_640X480_H_FP,
    parameter int unsigned H_SYNC     = VGA_640X480_H_SYNC,
    parameter int unsigned H_BP       = VGA_640X480_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_640X480_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_640X480_V_FP,
    parameter int unsigned V_SYNC     = VGA_640X480_V_SYNC,
    parameter int unsigned V_BP       = VGA_640X480_V_BP,
    parameter bit          SYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int unsigned COLOR_BITS = COLOR_BITS_DEFAULT,
    parameter int unsigned PIXEL_LAT  = 2,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned FRM_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pix_en,
    input  logic [pixel_width(COLOR_BITS)-1:0]   pixel_in,
    output logic [CNT_W-1:0]                     row,
    output logic [CNT_W-1:0]                     col,
    output logic                                 load_window,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic [pixel_width(COLOR_BITS)-1:0]   rgb_out,
    output logic                                 frame_irq,
    input  logic                                 irq_ack,
    output logic                                 irq_overrun,
    output logic [FRM_W-1:0]                     frame_cnt
);

    localparam int unsigned PIX_W    = pixel_width(COLOR_BITS);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             load_window_q, load_window_d;
    logic             frame_irq_q, frame_irq_d, irq_overrun_q, irq_overrun_d;

    logic             col_last, row_last, vblank_start;
    scan_ctl_t        ctl_raw, ctl_dly;

    assign col_last     = (col_q == CNT_W'(H_TOTAL - 1));
    assign row_last     = (row_q == CNT_W'(V_TOTAL - 1));
    assign vblank_start = pix_en && col_last && (row_q == CNT_W'(V_ACTIVE - 1));

    // Raw decode of the current scan position
    assign ctl_raw.act = (col_q < CNT_W'(H_ACTIVE)) && (row_q < CNT_W'(V_ACTIVE));
    assign ctl_raw.hs  = (col_q >= CNT_W'(HS_START)) && (col_q < CNT_W'(HS_END));
    assign ctl_raw.vs  = (row_q >= CNT_W'(VS_START)) && (row_q < CNT_W'(VS_END));

    // Reset value means "blanked, sync deasserted"
    emern_delay_line #(
        .W         (SCAN_CTL_W),
        .DEPTH     (PIXEL_LAT),
        .RESET_VAL ('0)
    ) u_ctl_dly (
        .clk  (clk),
        .rst  (rst),
        .en_i (pix_en),
        .d_i  (ctl_raw),
        .q_o  (ctl_dly)
    );

    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        frame_cnt_d   = frame_cnt_q;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_irq_d   = frame_irq_q;
        irq_overrun_d = irq_overrun_q;

        if (pix_en) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
            rgb_d   = ctl_dly.act ? pixel_in : '0;
            hsync_d = ctl_dly.hs ? SYNC_POL : ~SYNC_POL;
            vsync_d = ctl_dly.vs ? SYNC_POL : ~SYNC_POL;
        end

        // A coincident ack still clears overrun, but the new event keeps the irq raised
        if (vblank_start) begin
            frame_cnt_d   = frame_cnt_q + FRM_W'(1);
            frame_irq_d   = 1'b1;
            irq_overrun_d = irq_ack ? 1'b0 : (irq_overrun_q | frame_irq_q);
        end else if (irq_ack) begin
            frame_irq_d   = 1'b0;
            irq_overrun_d = 1'b0;
        end

        load_window_d = (row_d >= CNT_W'(V_ACTIVE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            frame_cnt_q   <= '0;
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            load_window_q <= 1'b0;
            frame_irq_q   <= 1'b0;
            irq_overrun_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            frame_cnt_q   <= frame_cnt_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            load_window_q <= load_window_d;
            frame_irq_q   <= frame_irq_d;
            irq_overrun_q <= irq_overrun_d;
        end
    end

    assign row         = row_q;
    assign col         = col_q;
    assign frame_cnt   = frame_cnt_q;
    assign rgb_out     = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign load_window = load_window_q;
    assign frame_irq   = frame_irq_q;
    assign irq_overrun = irq_overrun_q;

endmodule
